// File: rtl/ysyx_25040111_icache_axi_rd_pkg.sv
// ysyx_25040111_icache_axi_rd_pkg: AXI encodings and FSM states shared by the icache read bridge
package ysyx_25040111_icache_axi_rd_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_DRAIN = 2'd3} state_e;
endpackage

// File: rtl/ysyx_25040111_icache_axi_rd.sv
// ysyx_25040111_icache_axi_rd: read-only AXI4 master turning icache refill requests into bursts or single-beat reads
module ysyx_25040111_icache_axi_rd
    import ysyx_25040111_icache_axi_rd_pkg::*;
#(
    parameter int              ID_W = 4,
    parameter logic [ID_W-1:0] ARID = '0,
    parameter logic [2:0]      SIZE = AXI_SIZE_4B
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_chvalid,
    input  logic            i_chburst,
    input  logic [31:0]     i_chaddr,
    input  logic [7:0]      i_chlen,
    output logic            o_chready,
    output logic [31:0]     o_chdata,
    output logic            o_err,
    output logic            o_arvalid,
    output logic [31:0]     o_araddr,
    output logic [ID_W-1:0] o_arid,
    output logic [7:0]      o_arlen,
    output logic [2:0]      o_arsize,
    output logic [1:0]      o_arburst,
    input  logic            i_arready,
    input  logic            i_rvalid,
    input  logic [31:0]     i_rdata,
    input  logic [1:0]      i_rresp,
    input  logic            i_rlast,
    input  logic [ID_W-1:0] i_rid,
    output logic            o_rready
);
    state_e      r_state, w_next;
    logic [31:0] r_araddr, r_chdata;
    logic [7:0]  r_arlen, r_cnt;
    logic        r_mode, r_done, r_chready, r_err;
    logic        w_beat, w_last, w_bad, w_launch;

    assign w_launch = (r_state == S_IDLE) & i_chvalid & ~r_done;
    assign w_beat   = (r_state == S_R) & i_rvalid;
    assign w_last   = r_cnt == 8'd0;
    // single-beat reads are issued with arlen=0, so every one of their beats must carry rlast
    assign w_bad    = (i_rresp != AXI_RESP_OKAY) | (i_rid != ARID) | (i_rlast != (r_mode ? w_last : 1'b1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_launch ? S_AR : S_IDLE;
            S_AR:    w_next = i_arready ? S_R : S_AR;
            // a bad beat that already carries rlast ends the burst, so there is nothing to drain
            S_R:     w_next = !w_beat ? S_R :
                              w_bad ? ((r_mode & ~i_rlast) ? S_DRAIN : S_IDLE) :
                              w_last ? S_IDLE : (r_mode ? S_R : S_AR);
            S_DRAIN: w_next = (i_rvalid & i_rlast) ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_chready <= 1'b0;
            r_chdata  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_chready <= w_beat & ~w_bad;
            r_err     <= w_beat & w_bad;
            // done blocks relaunch until the cache lets go of chvalid
            r_done    <= (w_beat & (w_bad | w_last)) | (r_done & i_chvalid);
            if (w_beat & ~w_bad) r_chdata <= i_rdata;
            if (w_launch) begin
                r_araddr <= i_chaddr;
                r_arlen  <= i_chburst ? i_chlen : 8'd0;
                r_cnt    <= i_chlen;
                r_mode   <= i_chburst;
            end
            if (w_beat & ~w_bad & ~w_last) begin
                r_cnt <= r_cnt - 8'd1;
                if (!r_mode) r_araddr <= r_araddr + 32'd4;
            end
        end
    end

    assign o_chready = r_chready;
    assign o_chdata  = r_chdata;
    assign o_err     = r_err;
    assign o_arvalid = r_state == S_AR;
    assign o_araddr  = r_araddr;
    assign o_arid    = ARID;
    assign o_arlen   = r_arlen;
    assign o_arsize  = SIZE;
    assign o_arburst = AXI_BURST_INCR;
    assign o_rready  = (r_state == S_R) | (r_state == S_DRAIN);
endmodule
